// File: rtl/cancid_pkt_feeder_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cancid_pkt_feeder_if : tagged packet-byte stream (valid/ready)        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface cancid_pkt_feeder_if;
    logic [7:0] s_data;
    logic       s_vld;
    logic       s_sop;
    logic       s_eop;
    logic [5:0] s_stream_id;
    logic       s_rdy;

    modport master (output s_data, s_vld, s_sop, s_eop, s_stream_id, input s_rdy);
    modport slave  (input  s_data, s_vld, s_sop, s_eop, s_stream_id, output s_rdy);
endinterface
`default_nettype wire

// File: rtl/cancid_pkt_feeder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cancid_pkt_feeder : sequences tagged packets onto the finger-bank bus |
// | Optional watchdog: CANCID_FEEDER_TIMEOUT_EN            Rev 1.0        |
// +-----------------------------------------------------------------------+
module cancid_pkt_feeder #(
    parameter int unsigned EOP_DELAY = 2
`ifdef CANCID_FEEDER_TIMEOUT_EN
    , parameter int unsigned TIMEOUT = 1024
`endif
) (
    input  logic                clk,
    input  logic                rst,
    cancid_pkt_feeder_if.slave  s_bus,
    input  logic                cfg_we,
    input  logic [5:0]          cfg_stream_id,
    input  logic                cfg_enable,
    input  logic                clear_streams,
    output logic                load_state,
    output logic [5:0]          stream_id,
    output logic                new_stream_id,
    output logic [7:0]          char_in,
    output logic                char_in_vld,
    output logic                eop,
    output logic                enable,
    output logic                busy,
    output logic [15:0]         err_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_EOP    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  dcnt_q, dcnt_d;
    logic [63:0] seen_q, en_q;
    logic [5:0]  stream_id_q;
    logic        s_rdy_q, s_rdy_d;
    logic        load_q, new_q, cvld_q, eop_q, enable_q, busy_q;
    logic [7:0]  char_q;
    logic [15:0] err_q;

    logic        accept, drop, start, timeout_hit, abort;

    assign accept = s_bus.s_vld & s_rdy_q & (state_q == ST_STREAM);
    assign drop   = s_bus.s_vld & s_rdy_q & (state_q == ST_IDLE);
    // A held non-SOP beat is being dropped while s_rdy_q is up, so it never starts a packet.
    assign start  = s_bus.s_vld & s_bus.s_sop & ~s_rdy_q & (state_q == ST_IDLE);

`ifdef CANCID_FEEDER_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q;
    logic            abort_q;

    assign timeout_hit = (state_q == ST_STREAM) & ~s_bus.s_vld & (wd_q == WD_W'(TIMEOUT - 1));
    assign abort       = abort_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q    <= '0;
            abort_q <= 1'b0;
        end else begin
            wd_q <= ((state_q == ST_STREAM) && !s_bus.s_vld) ? wd_q + 1'b1 : '0;
            if (timeout_hit)
                abort_q <= 1'b1;
            else if (state_q == ST_IDLE)
                abort_q <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign abort       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_STREAM;
            ST_STREAM: begin
                if ((accept && s_bus.s_eop) || timeout_hit) begin
                    state_d = ST_DRAIN;
                    dcnt_d  = '0;
                end
            end
            ST_DRAIN: begin
                if (dcnt_q == 4'(EOP_DELAY - 1))
                    state_d = ST_EOP;
                else
                    dcnt_d = dcnt_q + 4'd1;
            end
            ST_EOP:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        s_rdy_d = (state_d == ST_STREAM) ||
                  ((state_q == ST_IDLE) && s_bus.s_vld && !s_bus.s_sop && !s_rdy_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dcnt_q      <= '0;
            seen_q      <= '0;
            en_q        <= '0;
            stream_id_q <= '0;
            s_rdy_q     <= 1'b0;
            load_q      <= 1'b0;
            new_q       <= 1'b0;
            char_q      <= '0;
            cvld_q      <= 1'b0;
            eop_q       <= 1'b0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            s_rdy_q  <= s_rdy_d;
            busy_q   <= (state_d != ST_IDLE);
            load_q   <= (state_q == ST_LOAD);
            cvld_q   <= accept;
            eop_q    <= (state_q == ST_EOP);
            enable_q <= (state_q == ST_EOP) && en_q[stream_id_q] && !abort;
            if (start)
                stream_id_q <= s_bus.s_stream_id;
            if (state_q == ST_LOAD)
                new_q <= ~seen_q[stream_id_q];
            if (accept)
                char_q <= s_bus.s_data;
            if (cfg_we)
                en_q[cfg_stream_id] <= cfg_enable;
            // Fingers only save state when enabled; clear overrides a same-cycle set.
            if (clear_streams)
                seen_q <= '0;
            else if ((state_q == ST_EOP) && en_q[stream_id_q] && !abort)
                seen_q[stream_id_q] <= 1'b1;
            if ((drop || timeout_hit) && (err_q != 16'hFFFF))
                err_q <= err_q + 16'd1;
        end
    end

    assign s_bus.s_rdy   = s_rdy_q;
    assign load_state    = load_q;
    assign stream_id     = stream_id_q;
    assign new_stream_id = new_q;
    assign char_in       = char_q;
    assign char_in_vld   = cvld_q;
    assign eop           = eop_q;
    assign enable        = enable_q;
    assign busy          = busy_q;
    assign err_cnt       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cancid_pkt_feeder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_cancid_pkt_feeder : scoreboard bench for cancid_pkt_feeder         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_cancid_pkt_feeder;
    localparam int EOP_DELAY = 2;
    localparam int K_LOAD = 0, K_CHAR = 1, K_EOP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [5:0]  cfg_stream_id = '0;
    logic        cfg_enable = 1'b0;
    logic        clear_streams = 1'b0;
    logic        load_state, new_stream_id, char_in_vld, eop, enable, busy;
    logic [5:0]  stream_id;
    logic [7:0]  char_in;
    logic [15:0] err_cnt;

    always #5 clk = ~clk;

    cancid_pkt_feeder_if bus ();

    cancid_pkt_feeder #(
        .EOP_DELAY(EOP_DELAY)
`ifdef CANCID_FEEDER_TIMEOUT_EN
        , .TIMEOUT(8)
`endif
    ) dut (
        .clk(clk), .rst(rst), .s_bus(bus.slave),
        .cfg_we(cfg_we), .cfg_stream_id(cfg_stream_id), .cfg_enable(cfg_enable),
        .clear_streams(clear_streams), .load_state(load_state), .stream_id(stream_id),
        .new_stream_id(new_stream_id), .char_in(char_in), .char_in_vld(char_in_vld),
        .eop(eop), .enable(enable), .busy(busy), .err_cnt(err_cnt)
    );

    typedef struct {
        int kind;
        int data;
        int flag;
        int off;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_load = 0;
    int   exp_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic ev(input int kind, input int data, input int flag);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d data %0h, expected none (cycle %0d)", kind, data, cyc);
        end else begin
            e = sb.pop_front();
            check("event_kind", kind, e.kind);
            check("event_data", data, e.data);
            if (kind != K_CHAR) check("event_flag", flag, e.flag);
            check("event_offset", cyc - last_load, e.off);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a finger-bus event.
    always @(negedge clk) begin
        cyc++;
        if (load_state) last_load = cyc;
        if (load_state)  ev(K_LOAD, int'(stream_id), int'(new_stream_id));
        if (char_in_vld) ev(K_CHAR, int'(char_in), 0);
        if (eop)         ev(K_EOP, int'(stream_id), int'(enable));
    end

    task automatic push(input int kind, input int data, input int flag, input int off);
        exp_t e;
        e.kind = kind; e.data = data; e.flag = flag; e.off = off;
        sb.push_back(e);
    endtask

    task automatic beat(input logic [7:0] d, input logic sop, input logic eb, input logic [5:0] id);
        logic acc;
        acc = 1'b0;
        bus.s_data = d; bus.s_sop = sop; bus.s_eop = eb; bus.s_stream_id = id; bus.s_vld = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = bus.s_rdy;
            @(posedge clk);
            #1;
        end
        if (!acc) check("beat_accept_timeout", 0, 1);
        bus.s_vld = 1'b0;
    endtask

    task automatic cfg(input logic [5:0] id, input logic en);
        cfg_we = 1'b1; cfg_stream_id = id; cfg_enable = en;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic pkt(input logic [5:0] id, input string s, input int nw, input int en,
                       input int gap_after, input int gap);
        int off;
        off = 2;
        push(K_LOAD, int'(id), nw, 0);
        for (int i = 0; i < s.len(); i++) begin
            push(K_CHAR, int'(s[i]), 0, off);
            off++;
            if (i == gap_after) off += gap;
        end
        push(K_EOP, int'(id), en, off - 1 + EOP_DELAY + 1);
        for (int i = 0; i < s.len(); i++) begin
            beat(s[i], (i == 0), (i == s.len() - 1), id);
            if (i == gap_after) repeat (gap) begin @(posedge clk); #1; end
        end
        repeat (6) begin @(posedge clk); #1; end
    endtask

    initial begin
        bus.s_data = '0; bus.s_vld = 1'b0; bus.s_sop = 1'b0; bus.s_eop = 1'b0; bus.s_stream_id = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_load_state", load_state, 0);
        check("rst_busy", busy, 0);
        check("rst_s_rdy", bus.s_rdy, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_eop", eop, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        cfg(6'd5, 1'b1);
        pkt(6'd5, "abc", 1, 1, -1, 0);
        pkt(6'd5, "de", 0, 1, -1, 0);
        clear_streams = 1'b1; @(posedge clk); #1; clear_streams = 1'b0;
        pkt(6'd5, "f", 1, 1, -1, 0);
        pkt(6'd9, "gh", 1, 0, -1, 0);
        pkt(6'd9, "i", 1, 0, -1, 0);

        // Stray non-SOP beat in IDLE is dropped and counted.
        beat(8'h55, 1'b0, 1'b0, 6'd3);
        exp_err++;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("drop_err_cnt", err_cnt, exp_err);
        check("drop_idle_busy", busy, 0);
        @(posedge clk); #1;

        pkt(6'd5, "A", 0, 1, -1, 0);
        pkt(6'd7, "xyz", 1, 0, 0, 2);

`ifdef CANCID_FEEDER_TIMEOUT_EN
        cfg(6'd12, 1'b1);
        push(K_LOAD, 12, 1, 0);
        push(K_CHAR, int'("a"), 0, 2);
        push(K_CHAR, int'("b"), 0, 3);
        push(K_EOP, 12, 0, 14);
        beat("a", 1'b1, 1'b0, 6'd12);
        beat("b", 1'b0, 1'b0, 6'd12);
        repeat (12) begin @(posedge clk); #1; end
        beat("c", 1'b0, 1'b1, 6'd12);
        exp_err += 2;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("timeout_err_cnt", err_cnt, exp_err);
        @(posedge clk); #1;
        pkt(6'd12, "d", 1, 1, -1, 0);
`endif

        // Reset while streaming: one byte reaches the fingers, then everything clears.
        push(K_LOAD, 5, 0, 0);
        push(K_CHAR, int'("p"), 0, 2);
        beat("p", 1'b1, 1'b0, 6'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_load_state", load_state, 0);
        check("midrst_char_in_vld", char_in_vld, 0);
        check("midrst_busy", busy, 0);
        check("midrst_s_rdy", bus.s_rdy, 0);
        check("midrst_err_cnt", err_cnt, 0);
        check("midrst_new_stream_id", new_stream_id, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        pkt(6'd5, "q", 1, 0, -1, 0);
        cfg(6'd5, 1'b1);
        pkt(6'd5, "r", 1, 1, -1, 0);
        pkt(6'd5, "s", 0, 1, -1, 0);

        repeat (10) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/cancid_pkt_feeder.md
Name: cancid_pkt_feeder

Overview:
Sequencer on the producer side of the per-stream regex-finger interface. It accepts packet bytes tagged with a 6-bit stream ID over a valid/ready bus and drives the shared finger-bank input bus: `load_state`, `stream_id`, `new_stream_id`, `char_in`, `char_in_vld`, `eop`, `enable`. It tracks which stream IDs have saved state and which are enabled, so the fingers know whether to restore or reset state. One packet is in flight at a time.

Parameters:
EOP_DELAY, 2, idle cycles between the last `char_in_vld` and the `eop` pulse; covers the finger accept_out latency; legal range 1..15.
TIMEOUT, 1024, mid-packet starvation limit in cycles; used only with the optional feature.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s_data  in  8  packet byte
s_vld  in  1  byte valid
s_sop  in  1  first byte of packet
s_eop  in  1  last byte of packet
s_stream_id  in  6  stream ID; sampled on the SOP beat only
s_rdy  out  1  byte accepted when s_vld&s_rdy
cfg_we  in  1  enable-table write strobe
cfg_stream_id  in  6  enable-table write address
cfg_enable  in  1  enable-table write data
clear_streams  in  1  clears all "seen" bits
load_state  out  1  one-cycle restore/reset request to fingers
stream_id  out  6  current stream ID; held from LOAD through EOP
new_stream_id  out  1  1 = no saved state for stream_id
char_in  out  8  byte to fingers
char_in_vld  out  1  char_in valid
eop  out  1  one-cycle end-of-packet pulse
enable  out  1  enable-table bit for stream_id; valid while eop=1
busy  out  1  state != IDLE
err_cnt  out  16  dropped-beat / abort counter, saturating

Behaviour:
- All outputs are registered. Reset value of every output and state bit is 0; the seen[63:0] and en[63:0] tables clear to 0. Reset mid-packet returns to IDLE with no eop issued.
- FSM states: IDLE, LOAD, SETTLE, STREAM, DRAIN, EOP.
- IDLE:
  - s_rdy=0.
  - If s_vld&s_sop: latch s_stream_id into stream_id, go to LOAD. The beat is not consumed.
  - If s_vld&!s_sop: s_rdy=1 for one cycle, the beat is dropped, err_cnt increments.
- LOAD: load_state=1 for exactly 1 cycle; new_stream_id = !seen[stream_id]. Next state is SETTLE.
- SETTLE: 1 cycle, so the finger's registered state_in/state_in_vld takes effect. Next state is STREAM. First possible char_in_vld is at LOAD+2.
- STREAM:
  - s_rdy=1.
  - Each accepted beat gives char_in<=s_data and char_in_vld=1 on the next cycle; otherwise char_in_vld=0. A stall (s_vld=0) inserts bubbles.
  - The accepted beat with s_eop goes to DRAIN. A single beat with both sop and eop is legal.
  - s_sop seen again mid-packet is ignored; the byte is treated as data.
- DRAIN: s_rdy=0. Counts EOP_DELAY cycles after the last char_in_vld, then goes to EOP.
- EOP:
  - eop=1 and enable=en[stream_id] for 1 cycle.
  - If enable=1, set seen[stream_id]. The finger saves state only when enabled, so a disabled stream stays "new".
  - Next state is IDLE. Back-to-back packets: next load_state no earlier than EOP+2.
- cfg_we writes en[cfg_stream_id] any cycle. A write to the current stream_id during EOP does not affect that EOP's enable, which samples the pre-write value.
- clear_streams zeros seen in the next cycle. If it coincides with an EOP set, clear wins. If it is asserted during LOAD, new_stream_id uses the pre-clear value.
- err_cnt saturates at 16'hFFFF.

Optional Feature:
CANCID_FEEDER_TIMEOUT_EN:
- Defined: a watchdog counts consecutive STREAM cycles with s_vld=0. At TIMEOUT it forces DRAIN then EOP with enable=0 regardless of en[]; the finger discards the speculative match and seen is not set. err_cnt increments and the rest of the packet is dropped as non-SOP beats in IDLE.
- Undefined: no watchdog; STREAM stalls indefinitely. Counter logic is absent.

Test Plan:
- Reset, cfg en[5]=1, packet id 5 bytes "abc" with no stalls → load_state at T with new_stream_id=1; char_in_vld at T+2..T+4; eop at T+7 with enable=1; seen[5]=1.
- Second packet id 5 → new_stream_id=0. Then clear_streams, third packet id 5 → new_stream_id=1.
- en[9]=0, packet id 9 → eop with enable=0; next packet id 9 → new_stream_id=1.
- Non-SOP beat in IDLE → dropped, s_rdy pulses 1 cycle, err_cnt=1, no load_state. Single sop&eop beat 0x41 → exactly one char_in_vld, then eop EOP_DELAY+1 cycles later.
- 2-cycle s_vld gap mid-packet → char_in_vld bubbles, byte order preserved. rst asserted in STREAM → all outputs 0 next cycle, no eop, seen cleared.
- (CANCID_FEEDER_TIMEOUT_EN, TIMEOUT=8) stall 8 cycles mid-packet → eop with enable=0, err_cnt+1, seen unchanged.
